// File: rtl/regfile_sweeper.sv
// rtl/regfile_sweeper.sv - fill/scan access initiator for a NUM_REGS x REG_SIZE register file
module regfile_sweeper #(
    parameter int NUM_REGS   = 8,
    parameter int REG_SIZE   = 4,
    parameter int ADDR_SIZE  = 3,
    parameter int DWELL      = 4,
    parameter int DWELL_SIZE = 16
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  FILL,
    input  logic                  SCAN,
    input  logic [REG_SIZE-1:0]   SEED,
    output logic [ADDR_SIZE-1:0]  WA,
    output logic [REG_SIZE-1:0]   DIN,
    output logic                  WrEn,
    output logic [ADDR_SIZE-1:0]  RA,
    input  logic [REG_SIZE-1:0]   DOUT,
    output logic [ADDR_SIZE-1:0]  RD_ADDR,
    output logic [REG_SIZE-1:0]   RD_DATA,
    output logic                  VALID,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SCAN
    } state_t;

    localparam logic [ADDR_SIZE-1:0]  LAST_ADDR  = ADDR_SIZE'(NUM_REGS - 1);
    localparam logic [DWELL_SIZE-1:0] LAST_DWELL = DWELL_SIZE'(DWELL - 1);

    state_t                 state;
    logic [DWELL_SIZE-1:0]  dwell;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= S_IDLE;
            WA      <= '0;
            DIN     <= '0;
            WrEn    <= 1'b0;
            RA      <= '0;
            RD_ADDR <= '0;
            RD_DATA <= '0;
            VALID   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            dwell   <= '0;
        end else begin
            VALID <= 1'b0;
            DONE  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // FILL has priority when both commands are raised together
                    if (FILL) begin
                        state <= S_FILL;
                        WA    <= '0;
                        DIN   <= SEED;
                        WrEn  <= 1'b1;
                        BUSY  <= 1'b1;
                    end else if (SCAN) begin
                        state <= S_SCAN;
                        RA    <= '0;
                        dwell <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (WA == LAST_ADDR) begin
                        state <= S_IDLE;
                        WrEn  <= 1'b0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        WA  <= WA + 1'b1;
                        DIN <= DIN + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (dwell == LAST_DWELL) begin
                        RD_DATA <= DOUT;
                        RD_ADDR <= RA;
                        VALID   <= 1'b1;
                        dwell   <= '0;
                        if (RA == LAST_ADDR) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            RA    <= '0;
                        end else begin
                            RA <= RA + 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sweeper.sv
// tb/tb_regfile_sweeper.sv - scoreboard bench for regfile_sweeper with behavioural register files
module tb_regfile_sweeper;

    typedef struct packed {
        logic [2:0] a;
        logic [3:0] d;
    } pair_t;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       FILL = 1'b0, SCAN = 1'b0, FILL1 = 1'b0, SCAN1 = 1'b0;
    logic [3:0] SEED = 4'h0;

    logic [2:0] WA, RA, RD_ADDR, WA1, RA1, RD_ADDR1;
    logic [3:0] DIN, DOUT, RD_DATA, DIN1, DOUT1, RD_DATA1;
    logic       WrEn, VALID, BUSY, DONE, WrEn1, VALID1, BUSY1, DONE1;

    logic [3:0] mem [8];
    logic [3:0] mem1 [8];
    logic [3:0] exp_mem [8];

    pair_t wq[$];
    pair_t rq[$];
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    regfile_sweeper #(.NUM_REGS(8), .REG_SIZE(4), .ADDR_SIZE(3), .DWELL(4), .DWELL_SIZE(16)) dut (
        .CLK(CLK), .CLR(CLR), .FILL(FILL), .SCAN(SCAN), .SEED(SEED),
        .WA(WA), .DIN(DIN), .WrEn(WrEn), .RA(RA), .DOUT(DOUT),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
    );

    regfile_sweeper #(.NUM_REGS(8), .REG_SIZE(4), .ADDR_SIZE(3), .DWELL(1), .DWELL_SIZE(16)) dut1 (
        .CLK(CLK), .CLR(CLR), .FILL(FILL1), .SCAN(SCAN1), .SEED(SEED),
        .WA(WA1), .DIN(DIN1), .WrEn(WrEn1), .RA(RA1), .DOUT(DOUT1),
        .RD_ADDR(RD_ADDR1), .RD_DATA(RD_DATA1), .VALID(VALID1), .BUSY(BUSY1), .DONE(DONE1)
    );

    // Register files: synchronous write, combinational read
    initial begin
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 4'h0;
            exp_mem[i] = 4'h0;
            mem1[i]    = 4'(i * 5 + 1);
        end
    end
    always @(posedge CLK) if (WrEn) mem[WA] <= DIN;
    always @(posedge CLK) if (WrEn1) mem1[WA1] <= DIN1;
    assign DOUT  = mem[RA];
    assign DOUT1 = mem1[RA1];

    function automatic void push_fill(input logic [3:0] seed, input int n);
        for (int i = 0; i < n; i++) begin
            wq.push_back('{a: 3'(i), d: 4'(seed + i)});
            exp_mem[i] = 4'(seed + i);
        end
    endfunction

    function automatic void push_scan();
        for (int i = 0; i < 8; i++) rq.push_back('{a: 3'(i), d: exp_mem[i]});
    endfunction

    // Entered on the negedge where FILL was raised; returns on the DONE negedge
    task automatic fill_check(input string name);
        int wcnt = 0, busy_cnt = 0;
        bit done_seen = 0, vflag = 0;
        pair_t e;
        for (int k = 1; k <= 30 && !done_seen; k++) begin
            @(negedge CLK);
            if (k == 1) FILL = 1'b0;
            if (BUSY) busy_cnt++;
            if (VALID) vflag = 1;
            if (WrEn) begin
                e = (wq.size() > 0) ? wq.pop_front() : '0;
                checks++;
                if ({WA, DIN} !== e) begin
                    failures++;
                    $display("FAIL %s_write%0d got WA=%0h DIN=%0h want WA=%0h DIN=%0h", name, wcnt, WA, DIN, e.a, e.d);
                end
                checks++;
                if (k != wcnt + 1) begin
                    failures++;
                    $display("FAIL %s_write_timing got cycle %0d want %0d", name, k, wcnt + 1);
                end
                wcnt++;
            end
            if (DONE) begin
                done_seen = 1;
                checks++;
                if (k != 9 || WrEn || BUSY) begin
                    failures++;
                    $display("FAIL %s_done got cycle %0d WrEn=%0b BUSY=%0b want cycle 9 WrEn=0 BUSY=0", name, k, WrEn, BUSY);
                end
            end
        end
        checks++;
        if (!done_seen || wcnt != 8 || busy_cnt != 8 || vflag || wq.size() != 0) begin
            failures++;
            $display("FAIL %s_summary got done=%0b writes=%0d busy=%0d valid=%0b left=%0d want 1/8/8/0/0",
                     name, done_seen, wcnt, busy_cnt, vflag, wq.size());
        end
    endtask

    // Entered on the negedge where SCAN was raised or is held
    task automatic scan_check(input string name);
        int idx = 0, busy_cnt = 0;
        bit done_seen = 0, wr_seen = 0;
        pair_t e;
        for (int k = 1; k <= 45 && !done_seen; k++) begin
            @(negedge CLK);
            if (k == 1) SCAN = 1'b0;
            if (BUSY) busy_cnt++;
            if (WrEn) wr_seen = 1;
            if (VALID) begin
                e = (rq.size() > 0) ? rq.pop_front() : '0;
                checks++;
                if ({RD_ADDR, RD_DATA} !== e) begin
                    failures++;
                    $display("FAIL %s_read%0d got RD_ADDR=%0h RD_DATA=%0h want %0h/%0h", name, idx, RD_ADDR, RD_DATA, e.a, e.d);
                end
                checks++;
                if (k != (idx + 1) * 4 + 1) begin
                    failures++;
                    $display("FAIL %s_valid_timing%0d got cycle %0d want %0d", name, idx, k, (idx + 1) * 4 + 1);
                end
                checks++;
                if (DONE !== (idx == 7)) begin
                    failures++;
                    $display("FAIL %s_done_align%0d got DONE=%0b want %0b", name, idx, DONE, idx == 7);
                end
                idx++;
            end else if (DONE) begin
                checks++;
                failures++;
                $display("FAIL %s_done_without_valid got DONE=1 want 0 at cycle %0d", name, k);
            end
            if (DONE) begin
                done_seen = 1;
                checks++;
                if (RA !== 3'd0 || BUSY !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_end_state got RA=%0h BUSY=%0b want 0/0", name, RA, BUSY);
                end
            end
        end
        checks++;
        if (!done_seen || idx != 8 || busy_cnt != 32 || wr_seen || rq.size() != 0) begin
            failures++;
            $display("FAIL %s_summary got done=%0b reads=%0d busy=%0d wren=%0b left=%0d want 1/8/32/0/0",
                     name, done_seen, idx, busy_cnt, wr_seen, rq.size());
        end
        @(negedge CLK);
        checks++;
        if (VALID !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_width got VALID=%0b DONE=%0b BUSY=%0b want 0/0/0", name, VALID, DONE, BUSY);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if ({WA, DIN, WrEn, RA, RD_ADDR, RD_DATA, VALID, BUSY, DONE} !== '0 ||
                {WA1, DIN1, WrEn1, RA1, RD_ADDR1, RD_DATA1, VALID1, BUSY1, DONE1} !== '0) begin
                failures++;
                $display("FAIL reset_idle%0d got WA=%0h DIN=%0h WrEn=%0b RA=%0h RD=%0h/%0h V=%0b B=%0b D=%0b want all 0",
                         k, WA, DIN, WrEn, RA, RD_ADDR, RD_DATA, VALID, BUSY, DONE);
            end
        end
    endtask

    task automatic test_fill();
        SEED = 4'hE;
        FILL = 1'b1;
        push_fill(4'hE, 8);
        fill_check("fill");
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || WrEn !== 1'b0 || WA !== 3'd7 || DIN !== 4'h5) begin
            failures++;
            $display("FAIL fill_hold got DONE=%0b WrEn=%0b WA=%0h DIN=%0h want 0/0/7/5", DONE, WrEn, WA, DIN);
        end
    endtask

    task automatic test_scan();
        SCAN = 1'b1;
        push_scan();
        scan_check("scan");
    endtask

    task automatic test_back_to_back();
        SEED = 4'h3;
        FILL = 1'b1;
        SCAN = 1'b1;
        push_fill(4'h3, 8);
        fill_check("both_fill");
        push_scan();
        scan_check("both_scan");
    endtask

    task automatic test_clr_midfill();
        int wcnt = 0;
        pair_t e;
        SEED = 4'hE;
        FILL = 1'b1;
        push_fill(4'hE, 4);
        for (int k = 1; k <= 10 && wcnt < 4; k++) begin
            @(negedge CLK);
            if (k == 1) FILL = 1'b0;
            if (WrEn) begin
                e = (wq.size() > 0) ? wq.pop_front() : '0;
                checks++;
                if ({WA, DIN} !== e) begin
                    failures++;
                    $display("FAIL clr_write%0d got WA=%0h DIN=%0h want %0h/%0h", wcnt, WA, DIN, e.a, e.d);
                end
                wcnt++;
                if (wcnt == 4) CLR = 1'b1;
            end
        end
        @(negedge CLK);
        CLR = 1'b0;
        checks++;
        if ({WrEn, BUSY, DONE, VALID, WA, DIN, RA} !== '0 || wcnt != 4) begin
            failures++;
            $display("FAIL clr_abort got WrEn=%0b BUSY=%0b DONE=%0b WA=%0h DIN=%0h writes=%0d want 0/0/0/0/0/4",
                     WrEn, BUSY, DONE, WA, DIN, wcnt);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || WrEn !== 1'b0) begin
                failures++;
                $display("FAIL clr_quiet%0d got DONE=%0b BUSY=%0b WrEn=%0b want 0/0/0", k, DONE, BUSY, WrEn);
            end
        end
        SCAN = 1'b1;
        push_scan();
        scan_check("clr_scan");
    endtask

    task automatic test_dwell1();
        int idx = 0, busy_cnt = 0;
        bit done_seen = 0;
        pair_t e;
        SCAN1 = 1'b1;
        for (int i = 0; i < 8; i++) rq.push_back('{a: 3'(i), d: 4'(i * 5 + 1)});
        for (int k = 1; k <= 20 && !done_seen; k++) begin
            @(negedge CLK);
            if (k == 1) SCAN1 = 1'b0;
            if (BUSY1) busy_cnt++;
            if (VALID1) begin
                e = (rq.size() > 0) ? rq.pop_front() : '0;
                checks++;
                if ({RD_ADDR1, RD_DATA1} !== e || k != idx + 2) begin
                    failures++;
                    $display("FAIL dwell1_read%0d got %0h/%0h at cycle %0d want %0h/%0h at %0d",
                             idx, RD_ADDR1, RD_DATA1, k, e.a, e.d, idx + 2);
                end
                idx++;
            end
            if (DONE1) done_seen = 1;
        end
        checks++;
        if (!done_seen || idx != 8 || busy_cnt != 8 || RA1 !== 3'd0 || BUSY1 !== 1'b0 || WrEn1 !== 1'b0) begin
            failures++;
            $display("FAIL dwell1_summary got done=%0b reads=%0d busy=%0d RA=%0h BUSY=%0b want 1/8/8/0/0",
                     done_seen, idx, busy_cnt, RA1, BUSY1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_scan();
        test_back_to_back();
        test_clr_midfill();
        test_dwell1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
